sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite blitter: erases the uncovered part of the previous sprite box, then draws the
// new sprite from an external row ROM, streaming window commands and RGB bytes to a TFT.
module sprite_blitter #(
  parameter int          SIZE    = 22,
  parameter int          FRAMES  = 3,
  parameter int          COORD_W = 9,
  parameter int          X0      = 5,
  parameter int          Y0      = 5,
  parameter logic [23:0] FG      = 24'hFFFFFF,
  parameter logic [23:0] BG      = 24'h000000,
  localparam int         FW      = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int         RW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               draw,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [FW-1:0]      frame,
  input  logic               mirror,
  output logic               busy,
  output logic               done,
  output logic [FW-1:0]      rom_frame,
  output logic [RW-1:0]      rom_row,
  input  logic [SIZE-1:0]    rom_data,
  input  logic               tft_busy,
  output logic               tft_transmit,
  output logic               tft_dc,
  output logic [7:0]         tft_data
);

  localparam int CW1 = COORD_W + 1;
  typedef logic [CW1-1:0] coord_t;
  typedef struct packed {
    coord_t xs;
    coord_t ys;
    coord_t w;
    coord_t h;
  } rect_t;
  localparam coord_t SZ = coord_t'(SIZE);

  typedef enum logic [2:0] {IDLE, PLAN, WINDOW, PIXELS, NEXT, FINISH} state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] xo_q, xo_d, yo_q, yo_d, xn_q, xn_d, yn_q, yn_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic               mirror_q, mirror_d;
  rect_t              rect_q [3];
  rect_t              rect_d [3];
  logic               v0_q, v0_d, v1_q, v1_d;
  logic [1:0]         idx_q, idx_d, bip_q, bip_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [RW-1:0]      col_q, col_d, row_q, row_d;
  logic               busy_q, busy_d, done_q, done_d, tx_q, tx_d, dc_q, dc_d;
  logic [7:0]         data_q, data_d;

  coord_t        ox, oy, nx, ny, dx, dy, adx, ady, xe, ye;
  logic          overlap, strobe, pix_on, byte_dc;
  logic [7:0]    byte_val;
  logic [RW-1:0] bit_idx;
  logic [23:0]   colour;
  rect_t         cur;

  function automatic logic [7:0] hi_b(coord_t v);
    logic [15:0] t;
    t = 16'(v);
    return t[15:8];
  endfunction

  function automatic logic [7:0] lo_b(coord_t v);
    logic [15:0] t;
    t = 16'(v);
    return t[7:0];
  endfunction

  always_comb begin
    ox      = coord_t'(xo_q);
    oy      = coord_t'(yo_q);
    nx      = coord_t'(xn_q);
    ny      = coord_t'(yn_q);
    dx      = nx - ox;
    dy      = ny - oy;
    adx     = dx[CW1-1] ? coord_t'(-dx) : dx;
    ady     = dy[CW1-1] ? coord_t'(-dy) : dy;
    overlap = (adx < SZ) && (ady < SZ);
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur = rect_q[0];
      2'd1:    cur = rect_q[1];
      default: cur = rect_q[2];
    endcase
  end

  // Slot 2 always holds the sprite; slots 0/1 are erase rectangles.
  always_comb begin
    xe       = cur.xs + cur.w - coord_t'(1);
    ye       = cur.ys + cur.h - coord_t'(1);
    bit_idx  = mirror_q ? col_q : RW'(SIZE - 1) - col_q;
    pix_on   = (idx_q == 2'd2) && rom_data[bit_idx];
    colour   = pix_on ? FG : BG;
    byte_dc  = 1'b1;
    byte_val = '0;
    if (state_q == PIXELS) begin
      case (bip_q)
        2'd0:    byte_val = colour[23:16];
        2'd1:    byte_val = colour[15:8];
        default: byte_val = colour[7:0];
      endcase
    end else begin
      case (wcnt_q)
        4'd0:    begin byte_dc = 1'b0; byte_val = 8'h2A; end
        4'd1:    byte_val = hi_b(cur.xs);
        4'd2:    byte_val = lo_b(cur.xs);
        4'd3:    byte_val = hi_b(xe);
        4'd4:    byte_val = lo_b(xe);
        4'd5:    begin byte_dc = 1'b0; byte_val = 8'h2B; end
        4'd6:    byte_val = hi_b(cur.ys);
        4'd7:    byte_val = lo_b(cur.ys);
        4'd8:    byte_val = hi_b(ye);
        4'd9:    byte_val = lo_b(ye);
        default: begin byte_dc = 1'b0; byte_val = 8'h2C; end
      endcase
    end
  end

  assign strobe = enable && !tft_busy && !tx_q && (state_q == WINDOW || state_q == PIXELS);

  always_comb begin
    state_d  = state_q;
    xo_d     = xo_q;
    yo_d     = yo_q;
    xn_d     = xn_q;
    yn_d     = yn_q;
    frame_d  = frame_q;
    mirror_d = mirror_q;
    rect_d   = rect_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    col_d    = col_q;
    row_d    = row_q;
    bip_d    = bip_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tx_d     = 1'b0;
    dc_d     = dc_q;
    data_d   = data_q;
    if (enable) begin
      if (strobe) begin
        tx_d   = 1'b1;
        dc_d   = byte_dc;
        data_d = byte_val;
      end
      unique case (state_q)
        IDLE: if (draw) begin
          xn_d     = x;
          yn_d     = y;
          frame_d  = frame;
          mirror_d = mirror;
          busy_d   = 1'b1;
          state_d  = PLAN;
        end
        PLAN: begin
          // Slot 0 is the H strip when overlapping, otherwise the whole old box.
          if (overlap) rect_d[0] = '{xs: ox, ys: (ny > oy) ? oy : ny + SZ, w: SZ, h: ady};
          else         rect_d[0] = '{xs: ox, ys: oy, w: SZ, h: SZ};
          rect_d[1] = '{xs: (nx > ox) ? ox : nx + SZ, ys: (ny > oy) ? ny : oy, w: adx, h: SZ - ady};
          rect_d[2] = '{xs: nx, ys: ny, w: SZ, h: SZ};
          v0_d      = !overlap || (dy != '0);
          v1_d      = overlap && (dx != '0);
          idx_d     = v0_d ? 2'd0 : (v1_d ? 2'd1 : 2'd2);
          wcnt_d    = '0;
          col_d     = '0;
          row_d     = '0;
          bip_d     = '0;
          state_d   = WINDOW;
        end
        WINDOW: if (strobe) begin
          if (wcnt_q == 4'd10) begin
            wcnt_d  = '0;
            state_d = PIXELS;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
        PIXELS: if (strobe) begin
          if (bip_q == 2'd2) begin
            bip_d = '0;
            if (coord_t'(col_q) == cur.w - coord_t'(1)) begin
              col_d = '0;
              if (coord_t'(row_q) == cur.h - coord_t'(1)) begin
                row_d   = '0;
                state_d = NEXT;
              end else begin
                row_d = row_q + RW'(1);
              end
            end else begin
              col_d = col_q + RW'(1);
            end
          end else begin
            bip_d = bip_q + 2'd1;
          end
        end
        NEXT: begin
          if (idx_q == 2'd0 && v1_q) begin
            idx_d   = 2'd1;
            state_d = WINDOW;
          end else if (idx_q != 2'd2) begin
            idx_d   = 2'd2;
            state_d = WINDOW;
          end else begin
            state_d = FINISH;
          end
        end
        FINISH: begin
          xo_d    = xn_q;
          yo_d    = yn_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      xo_q     <= COORD_W'(X0);
      yo_q     <= COORD_W'(Y0);
      xn_q     <= '0;
      yn_q     <= '0;
      frame_q  <= '0;
      mirror_q <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) rect_q[i] <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      idx_q    <= '0;
      wcnt_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      bip_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_q     <= 1'b0;
      dc_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      xo_q     <= xo_d;
      yo_q     <= yo_d;
      xn_q     <= xn_d;
      yn_q     <= yn_d;
      frame_q  <= frame_d;
      mirror_q <= mirror_d;
      rect_q   <= rect_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      bip_q    <= bip_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tx_q     <= tx_d;
      dc_q     <= dc_d;
      data_q   <= data_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rom_frame    = frame_q;
  assign rom_row      = row_q;
  assign tft_transmit = tx_q;
  assign tft_dc       = dc_q;
  assign tft_data     = data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a byte-stream model built from rectangle rules is compared
// against every strobed byte, with directed literal checks and randomized draws.
module tb_sprite_blitter;
  localparam int          SIZE   = 22;
  localparam int          FRAMES = 3;
  localparam int          CW     = 9;
  localparam int          M      = (1 << (CW + 1)) - 1;
  localparam logic [23:0] FG     = 24'hFFFFFF;
  localparam logic [23:0] BG     = 24'h000000;

  logic            clk = 1'b0;
  logic            rst, enable, draw, mirror, tft_busy;
  logic [CW-1:0]   x, y;
  logic [1:0]      frame, rom_frame;
  logic [4:0]      rom_row;
  logic [SIZE-1:0] rom_data;
  logic            busy, done, tft_transmit, tft_dc;
  logic [7:0]      tft_data;

  logic [SIZE-1:0] rom_mem [4][SIZE];
  logic [8:0]      expq [$];
  logic [7:0]      cap [$];
  int              checks = 0, passes = 0, byte_cnt = 0, done_cnt = 0;
  int              mox, moy, hold_cnt = 0;
  bit              rand_busy = 0, rand_en = 0;
  logic            pbusy = 1'b0, ptx = 1'b0, pen = 1'b1;

  sprite_blitter #(.SIZE(SIZE), .FRAMES(FRAMES), .COORD_W(CW), .X0(5), .Y0(5),
                   .FG(FG), .BG(BG)) dut (
    .clk(clk), .rst(rst), .enable(enable), .draw(draw), .x(x), .y(y), .frame(frame),
    .mirror(mirror), .busy(busy), .done(done), .rom_frame(rom_frame), .rom_row(rom_row),
    .rom_data(rom_data), .tft_busy(tft_busy), .tft_transmit(tft_transmit),
    .tft_dc(tft_dc), .tft_data(tft_data));

  initial forever #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_frame][rom_row];

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, req);
  endtask

  // Byte sink / protocol monitor.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (tft_transmit) begin
        chk(!pbusy && !ptx && pen, "strobe_protocol", {pbusy, ptx, pen}, 3'b001);
        chk(expq.size() > 0, "extra_byte", byte_cnt, 0);
        if (expq.size() > 0) begin
          logic [8:0] e;
          e = expq.pop_front();
          chk({tft_dc, tft_data} == e, "byte_stream", {tft_dc, tft_data}, e);
        end
        cap.push_back(tft_data);
        byte_cnt++;
      end
      if (done) done_cnt++;
    end
    pbusy = tft_busy;
    ptx   = tft_transmit;
    pen   = enable;
  end

  initial begin
    tft_busy = 1'b0;
    enable   = 1'b1;
    forever begin
      @(posedge clk); #1;
      tft_busy = (hold_cnt > 0) || (rand_busy && $urandom_range(0, 3) == 0);
      if (hold_cnt > 0) hold_cnt--;
      enable = !(rand_en && $urandom_range(0, 15) == 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: actual %0d required %0d", 1, 0);
    $fatal(1, "watchdog");
  end

  task automatic push_b(input bit dc, input int v);
    expq.push_back({dc, 8'(v)});
  endtask

  task automatic push_rect(input int xs, input int ys, input int w, input int h,
                           input bit spr, input int f, input bit m);
    int xe, ye;
    xs = xs & M; ys = ys & M;
    xe = (xs + w - 1) & M; ye = (ys + h - 1) & M;
    push_b(0, 'h2A); push_b(1, xs >> 8); push_b(1, xs & 255); push_b(1, xe >> 8); push_b(1, xe & 255);
    push_b(0, 'h2B); push_b(1, ys >> 8); push_b(1, ys & 255); push_b(1, ye >> 8); push_b(1, ye & 255);
    push_b(0, 'h2C);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        logic [SIZE-1:0] row;
        logic [23:0]     col;
        row = rom_mem[f][r];
        col = BG;
        if (spr && (m ? row[c] : row[SIZE-1-c])) col = FG;
        push_b(1, col[23:16]); push_b(1, col[15:8]); push_b(1, col[7:0]);
      end
  endtask

  task automatic model_op(input int nx, input int ny, input int f, input bit m);
    int dx, dy, adx, ady;
    dx = nx - mox; dy = ny - moy;
    adx = (dx < 0) ? -dx : dx; ady = (dy < 0) ? -dy : dy;
    if (adx < SIZE && ady < SIZE) begin
      if (dy != 0) push_rect(mox, (ny > moy) ? moy : ny + SIZE, SIZE, ady, 0, 0, 0);
      if (dx != 0) push_rect((nx > mox) ? mox : nx + SIZE, (ny > moy) ? ny : moy, adx, SIZE - ady, 0, 0, 0);
    end else begin
      push_rect(mox, moy, SIZE, SIZE, 0, 0, 0);
    end
    push_rect(nx, ny, SIZE, SIZE, 1, f, m);
  endtask

  task automatic start_draw(input int nx, input int ny, input int f, input bit m);
    int cyc;
    x = CW'(nx); y = CW'(ny); frame = 2'(f); mirror = m; draw = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!busy && cyc < 200);
    draw = 1'b0;
    chk(busy, "draw_accept", busy, 1);
  endtask

  task automatic run_op(input int nx, input int ny, input int f, input bit m,
                        input int exp_total, input bit poke);
    int b0, d0, n_exp, cyc;
    chk(expq.size() == 0, "queue_empty_before_op", expq.size(), 0);
    expq.delete();
    model_op(nx, ny, f, m);
    n_exp = expq.size();
    cap.delete();
    b0 = byte_cnt; d0 = done_cnt;
    start_draw(nx, ny, f, m);
    if (poke) begin
      repeat (20) @(posedge clk);
      #1 x = CW'(200); y = CW'(200); draw = 1'b1;
      @(posedge clk); #1 draw = 1'b0;
    end
    cyc = 0;
    while (busy && cyc < 30000) begin @(posedge clk); #1; cyc++; end
    chk(!busy, "op_timeout", cyc, 30000);
    repeat (3) @(posedge clk);
    #1;
    chk(byte_cnt - b0 == n_exp, "byte_count_model", byte_cnt - b0, n_exp);
    if (exp_total >= 0) chk(byte_cnt - b0 == exp_total, "byte_count_literal", byte_cnt - b0, exp_total);
    chk(done_cnt - d0 == 1, "done_pulses", done_cnt - d0, 1);
    chk(expq.size() == 0, "stream_drained", expq.size(), 0);
    expq.delete();
    mox = nx; moy = ny;
  endtask

  initial begin
    int b0, cyc, bc1;
    rst = 1'b0; draw = 1'b0; x = '0; y = '0; frame = '0; mirror = 1'b0;
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < SIZE; r++) rom_mem[f][r] = SIZE'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk(busy == 0, "reset_busy", busy, 0);
    chk(done == 0, "reset_done", done, 0);
    chk(tft_transmit == 0, "reset_tx", tft_transmit, 0);
    chk({tft_dc, tft_data} == 9'h0, "reset_dc_data", {tft_dc, tft_data}, 0);
    chk({rom_row, rom_frame} == 7'h0, "reset_rom_addr", {rom_row, rom_frame}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    mox = 5; moy = 5;

    run_op(5, 5, 0, 0, 1463, 0);
    chk(cap[2] == 5 && cap[4] == 26, "first_win_x", {cap[2], cap[4]}, {8'd5, 8'd26});
    chk(cap[7] == 5 && cap[9] == 26, "first_win_y", {cap[7], cap[9]}, {8'd5, 8'd26});

    run_op(7, 5, 0, 0, 1606, 0);
    chk(cap[2] == 5 && cap[4] == 6, "vstrip_x", {cap[2], cap[4]}, {8'd5, 8'd6});
    chk(cap[7] == 5 && cap[9] == 26, "vstrip_y", {cap[7], cap[9]}, {8'd5, 8'd26});
    chk(cap[145] == 7 && cap[147] == 28, "sprite_after_v_x", {cap[145], cap[147]}, {8'd7, 8'd28});

    run_op(5, 5, 0, 0, -1, 0);
    run_op(7, 8, 0, 0, 1797, 0);
    chk(cap[4] == 26 && cap[7] == 5 && cap[9] == 7, "hstrip_win", {cap[4], cap[7], cap[9]}, {8'd26, 8'd5, 8'd7});
    chk(cap[213] == 6 && cap[216] == 8 && cap[218] == 26, "vstrip2_win",
        {cap[213], cap[216], cap[218]}, {8'd6, 8'd8, 8'd26});

    run_op(5, 5, 0, 0, -1, 0);
    run_op(100, 100, 0, 0, 2926, 0);
    chk(cap[2] == 5 && cap[4] == 26, "full_erase_x", {cap[2], cap[4]}, {8'd5, 8'd26});
    chk(cap[1465] == 100 && cap[1467] == 121, "far_sprite_x", {cap[1465], cap[1467]}, {8'd100, 8'd121});

    rom_mem[1][0] = {1'b1, {(SIZE-1){1'b0}}};
    run_op(100, 100, 1, 1, 1463, 0);
    chk(cap[11] == 8'h00 && cap[13] == 8'h00, "mirror_pixel0_bg", {cap[11], cap[13]}, 0);
    chk(cap[74] == 8'hFF && cap[76] == 8'hFF, "mirror_pixel21_fg", {cap[74], cap[76]}, 16'hFFFF);

    // Reset in the middle of a transfer.
    model_op(40, 40, 2, 0);
    b0 = byte_cnt;
    start_draw(40, 40, 2, 0);
    cyc = 0;
    while (byte_cnt - b0 < 300 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    chk(byte_cnt - b0 >= 300, "pre_reset_bytes", byte_cnt - b0, 300);
    rst = 1'b0;
    #1;
    chk({busy, done, tft_transmit, tft_dc, tft_data} == '0, "midop_reset_outputs",
        {busy, done, tft_transmit, tft_dc, tft_data}, 0);
    chk({rom_row, rom_frame} == 7'h0, "midop_reset_rom", {rom_row, rom_frame}, 0);
    expq.delete();
    mox = 5; moy = 5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    run_op(5, 5, 0, 0, 1463, 0);

    rand_busy = 1; rand_en = 1;
    for (int i = 0; i < 5; i++) begin
      int nx, ny;
      if ($urandom_range(0, 1) == 0) begin
        nx = mox + $urandom_range(0, 2 * SIZE) - SIZE; if (nx < 0) nx = 0;
        ny = moy + $urandom_range(0, 2 * SIZE) - SIZE; if (ny < 0) ny = 0;
      end else begin
        nx = $urandom_range(0, 400);
        ny = $urandom_range(0, 400);
      end
      run_op(nx, ny, $urandom_range(0, FRAMES - 1), 1'($urandom_range(0, 1)), -1, i == 0);
    end
    rand_busy = 0; rand_en = 0;
    repeat (2) @(posedge clk);
    #1;

    // Long back-pressure hold in the middle of the pixel stream.
    fork
      run_op(mox + 3, moy, 0, 0, -1, 0);
      begin
        int c2, s0;
        s0 = byte_cnt; c2 = 0;
        while (byte_cnt - s0 < 500 && c2 < 20000) begin @(posedge clk); #1; c2++; end
        hold_cnt = 51;
        @(posedge clk); #1;
        @(posedge clk); #2;
        bc1 = byte_cnt;
        repeat (47) @(posedge clk);
        #2;
        chk(byte_cnt == bc1, "stall_no_strobe", byte_cnt - bc1, 0);
      end
    join

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
